// File: rtl/popcount_acc.sv
// XNOR-popcount accumulator: masked beat -> registered adder tree -> saturating
// group accumulator emitting one signed sum per i_last-terminated group.
module popcount_acc #(
  parameter int  DATA_W  = 64,
  parameter int  ACC_W   = 16,
  parameter bit  XNOR_EN = 1'b1,
  localparam int LEN_W   = $clog2(DATA_W) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] stream_i,
  input  logic [DATA_W-1:0] weight_i,
  input  logic              i_val,
  input  logic              i_last,
  input  logic [LEN_W-1:0]  i_len,
  output logic [ACC_W-1:0]  stream_o,
  output logic              o_val,
  output logic              o_sat
);

  localparam int LVLS = $clog2(DATA_W);

  logic [DATA_W-1:0] x_s;
  logic [DATA_W-1:0] xm_s;
  logic [LEN_W-1:0]  n_s;

  // Beat preprocessing: optional XNOR, effective bit count, tail masking.
  always_comb begin
    x_s  = XNOR_EN ? ~(stream_i ^ weight_i) : stream_i;
    n_s  = LEN_W'(DATA_W);
    xm_s = '0;
    if (i_last && (i_len != '0) && (i_len <= LEN_W'(DATA_W))) begin
      n_s = i_len;
    end else begin
      n_s = LEN_W'(DATA_W);
    end
    for (int j = 0; j < DATA_W; j++) begin
      xm_s[j] = x_s[j] & (LEN_W'(j) < n_s);
    end
  end

  // Adder tree: level k holds DATA_W>>k partial counts of k+1 bits each.
  for (genvar k = 1; k <= LVLS; k++) begin : g_lvl
    localparam int NK = DATA_W >> k;
    logic [k:0] sum_q [NK];
    if (k == 1) begin : g_first
      always_ff @(posedge clk) begin
        for (int j = 0; j < NK; j++) begin
          sum_q[j] <= {1'b0, xm_s[2*j]} + {1'b0, xm_s[2*j+1]};
        end
      end
    end else begin : g_rest
      always_ff @(posedge clk) begin
        for (int j = 0; j < NK; j++) begin
          sum_q[j] <= {1'b0, g_lvl[k-1].sum_q[2*j]} + {1'b0, g_lvl[k-1].sum_q[2*j+1]};
        end
      end
    end
  end

  logic [LVLS-1:0] val_q;
  logic [LVLS-1:0] last_q;
  logic [LEN_W-1:0] n_q [LVLS];

  // Valid sideband shadows the tree; clearing it on reset discards in-flight beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      val_q <= '0;
    end else begin
      val_q[0] <= i_val;
      for (int k = 1; k < LVLS; k++) begin
        val_q[k] <= val_q[k-1];
      end
    end
  end

  // Last flag and bit count ride alongside the tree without reset.
  always_ff @(posedge clk) begin
    last_q[0] <= i_last;
    n_q[0]    <= n_s;
    for (int k = 1; k < LVLS; k++) begin
      last_q[k] <= last_q[k-1];
      n_q[k]    <= n_q[k-1];
    end
  end

  logic [LVLS:0]         pc_s;
  logic signed [ACC_W:0] v_s;
  logic signed [ACC_W:0] sum_s;
  logic [ACC_W-1:0]      clamp_s;
  logic                  ovf_s;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic                  sticky_q, sticky_d;
  logic [ACC_W-1:0]      out_q, out_d;
  logic                  oval_q, oval_d;
  logic                  osat_q, osat_d;

  assign pc_s = g_lvl[LVLS].sum_q[0];

  // Beat value 2*pc-n, saturating add, group close-out on the last beat.
  always_comb begin
    acc_d    = acc_q;
    sticky_d = sticky_q;
    out_d    = out_q;
    osat_d   = osat_q;
    oval_d   = 1'b0;
    v_s      = $signed({{(ACC_W-LVLS-1){1'b0}}, pc_s, 1'b0})
             - $signed({{(ACC_W-LVLS){1'b0}}, n_q[LVLS-1]});
    sum_s    = $signed({acc_q[ACC_W-1], acc_q}) + v_s;
    // The sum always fits ACC_W+1 bits, so overflow shows as the top two bits differing.
    ovf_s    = sum_s[ACC_W] != sum_s[ACC_W-1];
    if (ovf_s) begin
      clamp_s = sum_s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      clamp_s = sum_s[ACC_W-1:0];
    end
    if (val_q[LVLS-1] && last_q[LVLS-1]) begin
      out_d    = clamp_s;
      osat_d   = sticky_q | ovf_s;
      oval_d   = 1'b1;
      acc_d    = '0;
      sticky_d = 1'b0;
    end else if (val_q[LVLS-1]) begin
      acc_d    = clamp_s;
      sticky_d = sticky_q | ovf_s;
    end else begin
      acc_d    = acc_q;
      sticky_d = sticky_q;
    end
  end

  // Accumulator and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      sticky_q <= 1'b0;
      out_q    <= '0;
      oval_q   <= 1'b0;
      osat_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      sticky_q <= sticky_d;
      out_q    <= out_d;
      oval_q   <= oval_d;
      osat_q   <= osat_d;
    end
  end

  assign stream_o = out_q;
  assign o_val    = oval_q;
  assign o_sat    = osat_q;

endmodule

// File: tb/tb_popcount_acc.sv
// Scoreboard bench: a 16-bit and an 8-bit accumulator instance share one stimulus stream.
module tb_popcount_acc;
  localparam int DATA_W  = 64;
  localparam int LEN_W   = 7;
  localparam int LATENCY = 7;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct {
    int sum;
    bit sat;
    int cyc;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_val = 1'b0;
  logic              i_last = 1'b0;
  logic [LEN_W-1:0]  i_len = '0;
  logic [DATA_W-1:0] stream_i = '0;
  logic [DATA_W-1:0] weight_i = '0;
  logic [15:0]       so16;
  logic              ov16, sat16;
  logic [7:0]        so8;
  logic              ov8, sat8;

  exp_t q16[$];
  exp_t q8[$];
  exp_t e16, e8;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   n_push = 0;
  int   n_out16 = 0;
  int   n_out8 = 0;
  int   m_acc16 = 0;
  int   m_acc8 = 0;
  bit   m_sat16 = 1'b0;
  bit   m_sat8 = 1'b0;

  popcount_acc #(.DATA_W(64), .ACC_W(16), .XNOR_EN(1'b1)) dut16 (
    .clk(clk), .rst(rst), .stream_i(stream_i), .weight_i(weight_i),
    .i_val(i_val), .i_last(i_last), .i_len(i_len),
    .stream_o(so16), .o_val(ov16), .o_sat(sat16)
  );

  popcount_acc #(.DATA_W(64), .ACC_W(8), .XNOR_EN(1'b1)) dut8 (
    .clk(clk), .rst(rst), .stream_i(stream_i), .weight_i(weight_i),
    .i_val(i_val), .i_last(i_last), .i_len(i_len),
    .stream_o(so8), .o_val(ov8), .o_sat(sat8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic signed [31:0] got, input int want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic int beat_val(input logic [63:0] s, input logic [63:0] w,
                                  input logic l, input logic [LEN_W-1:0] len);
    int n;
    int pc;
    logic [63:0] x;
    n = 64;
    if (l && len != 0 && len <= 64) n = int'(len);
    x = ~(s ^ w);
    pc = 0;
    for (int j = 0; j < n; j++) pc += int'(x[j]);
    return 2 * pc - n;
  endfunction

  task automatic acc_step(inout int acc, inout bit st, input int v, input int w);
    int hi;
    int lo;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    acc = acc + v;
    if (acc > hi) begin acc = hi; st = 1'b1; end
    else if (acc < lo) begin acc = lo; st = 1'b1; end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic drive(input bit r, input bit v, input bit l, input logic [LEN_W-1:0] len,
                       input logic [63:0] s, input logic [63:0] w);
    int   bv;
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; i_val = v; i_last = l; i_len = len; stream_i = s; weight_i = w;
    if (r) begin
      m_acc16 = 0; m_sat16 = 1'b0; m_acc8 = 0; m_sat8 = 1'b0;
    end else if (v) begin
      bv = beat_val(s, w, l, len);
      acc_step(m_acc16, m_sat16, bv, 16);
      acc_step(m_acc8, m_sat8, bv, 8);
      if (l) begin
        e.cyc = cyc + LATENCY;
        e.sum = m_acc16; e.sat = m_sat16; q16.push_back(e);
        e.sum = m_acc8;  e.sat = m_sat8;  q8.push_back(e);
        n_push++;
        m_acc16 = 0; m_sat16 = 1'b0; m_acc8 = 0; m_sat8 = 1'b0;
      end
    end
  endtask

  // Output monitor for the 16-bit instance: each expectation must land on its exact cycle.
  always @(negedge clk) begin
    if (ov16 === 1'b1) n_out16++;
    if (q16.size() > 0 && q16[0].cyc == cyc) begin
      e16 = q16.pop_front();
      check_eq("oval16", ov16, 1);
      if (ov16 === 1'b1) begin
        check_eq("sum16", $signed(so16), e16.sum);
        check_eq("sat16", sat16, int'(e16.sat));
      end
    end else if (ov16 !== 1'b0) begin
      check_eq("spurious_oval16", ov16, 0);
    end
  end

  // Output monitor for the 8-bit instance.
  always @(negedge clk) begin
    if (ov8 === 1'b1) n_out8++;
    if (q8.size() > 0 && q8[0].cyc == cyc) begin
      e8 = q8.pop_front();
      check_eq("oval8", ov8, 1);
      if (ov8 === 1'b1) begin
        check_eq("sum8", $signed(so8), e8.sum);
        check_eq("sat8", sat8, int'(e8.sat));
      end
    end else if (ov8 !== 1'b0) begin
      check_eq("spurious_oval8", ov8, 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int glen;
    // Reset with valid beats present; they must be dropped.
    repeat (3) drive(1'b1, 1'b1, 1'b1, 7'd0, ONES, ONES);
    @(negedge clk);
    check_eq("rst_stream16", so16, 0);
    check_eq("rst_oval16", ov16, 0);
    check_eq("rst_sat16", sat16, 0);
    check_eq("rst_stream8", so8, 0);
    check_eq("rst_oval8", ov8, 0);
    check_eq("rst_sat8", sat8, 0);

    // Single full beats: +64 and -64.
    drive(1'b0, 1'b1, 1'b1, 7'd0, ONES, ONES);
    drive(1'b0, 1'b1, 1'b1, 7'd0, 64'd0, ONES);
    // Three-beat group, popcounts 32, 40, 0 with a bubble before the last beat.
    drive(1'b0, 1'b1, 1'b0, 7'd0, ONES, 64'h0000_0000_FFFF_FFFF);
    drive(1'b0, 1'b1, 1'b0, 7'd0, ONES, 64'h0000_00FF_FFFF_FFFF);
    drive(1'b0, 1'b0, 1'b1, 7'd0, ONES, ONES);
    drive(1'b0, 1'b1, 1'b1, 7'd0, ONES, 64'd0);
    // Partial last beat: +10, then -10 with ones only in the masked region.
    drive(1'b0, 1'b1, 1'b1, 7'd10, ONES, ONES);
    drive(1'b0, 1'b1, 1'b1, 7'd10, ONES, 64'hFFFF_FFFF_FFFF_FC00);
    // Saturation in the 8-bit instance, then a clean group.
    drive(1'b0, 1'b1, 1'b0, 7'd0, ONES, ONES);
    drive(1'b0, 1'b1, 1'b0, 7'd0, ONES, ONES);
    drive(1'b0, 1'b1, 1'b1, 7'd0, ONES, ONES);
    drive(1'b0, 1'b1, 1'b1, 7'd0, 64'd0, ONES);

    // Random streaming with one mid-group reset.
    for (int g = 0; g < 1000; g++) begin
      if (g == 500) begin
        repeat (LATENCY + 2) drive(1'b0, 1'b1, 1'b0, 7'd0, rnd64(), rnd64());
        drive(1'b1, 1'b1, 1'b1, 7'd0, ONES, ONES);
      end
      glen = $urandom_range(1, 4);
      for (int b = 0; b < glen; b++) begin
        logic [63:0] s;
        logic [63:0] w;
        while ($urandom_range(0, 3) == 0) begin
          drive(1'b0, 1'b0, 1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)), rnd64(), rnd64());
        end
        s = rnd64();
        case ($urandom_range(0, 3))
          0:       w = s;
          1:       w = ~s;
          default: w = rnd64();
        endcase
        drive(1'b0, 1'b1, (b == glen - 1), 7'($urandom_range(0, 127)), s, w);
      end
    end

    repeat (LATENCY + 3) drive(1'b0, 1'b0, 1'b0, 7'd0, ONES, ONES);
    @(negedge clk);
    check_eq("pending16", q16.size(), 0);
    check_eq("pending8", q8.size(), 0);
    check_eq("outcount16", n_out16, n_push);
    check_eq("outcount8", n_out8, n_push);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
